// File: rtl/saida_bcd_seq_if.sv
// Request/result bundle of the sequential binary-to-BCD display stage.
// Valid/ready: a request is taken on any rising edge where start=1 and busy=0; done pulses for one cycle with the result.
interface saida_bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    entrada;
  logic                start;
  logic                blank_zeros;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [4*DIGITS-1:0] digitos;
  logic [7*DIGITS-1:0] saida;
  logic [1:0]          dbg_state;

  modport master (
    output entrada, start, blank_zeros,
    input  busy, done, overflow, digitos, saida, dbg_state
  );

  modport slave (
    input  entrada, start, blank_zeros,
    output busy, done, overflow, digitos, saida, dbg_state
  );
endinterface

// File: rtl/saida_bcd_seq.sv
// Iterative double-dabble converter driving one seven-segment decoder per digit.
// Results are registered, so the displays change only when a conversion finishes.
module displayss (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  // Active-high segments, bit order gfedcba; code 14 shows 'E', code 15 is blank.
  always_comb begin
    seg_o = 7'h00;
    case (digit_i)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      4'd14:   seg_o = 7'h79;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

module saida_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 5
) (
  input logic           clock,
  input logic           reset,
  saida_bcd_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT   = pow10(DIGITS);
  localparam logic [63:0] MAX_IN  = (64'd1 << WIDTH) - 64'd1;
  localparam bit          CAN_OVF = (LIMIT <= MAX_IN);

  logic [1:0]        state_q, state_d;
  logic [BCDW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              blank_q, blank_d;
  logic [BCDW-1:0]   dig_q, dig_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              too_big;
  logic [BCDW-1:0]   acc_adj;
  logic [BCDW-1:0]   fin_digits;
  logic [7*DIGITS-1:0] seg_w;

  // When no WIDTH-bit value can reach 10^DIGITS the compare is not built at all.
  generate
    if (CAN_OVF) begin : g_ovf
      assign too_big = (64'(bus.entrada) >= LIMIT);
    end else begin : g_no_ovf
      assign too_big = 1'b0;
    end
  endgenerate

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else                         acc_adj[4*i +: 4] = acc_q[4*i +: 4];
    end
  end

  // Blank zeros above the most significant non-zero digit; the units digit always shows.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    fin_digits = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (blank_q && !seen && (acc_q[4*i +: 4] == 4'd0) && (i != 0))
        fin_digits[4*i +: 4] = 4'hF;
      else
        fin_digits[4*i +: 4] = acc_q[4*i +: 4];
      if (acc_q[4*i +: 4] != 4'd0) seen = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    blank_d = blank_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          blank_d = bus.blank_zeros;
          if (too_big) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            err_d   = 1'b0;
            acc_d   = '0;
            sh_d    = bus.entrada;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        {acc_d, sh_d} = {acc_adj, sh_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (err_q) begin
          dig_d = {DIGITS{4'hE}};
          ovf_d = 1'b1;
        end else begin
          dig_d = fin_digits;
          ovf_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
      dig_q   <= {DIGITS{4'hF}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_disp
      displayss u_disp (
        .digit_i (dig_q[4*g +: 4]),
        .seg_o   (seg_w[7*g +: 7])
      );
    end
  endgenerate

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.digitos   = dig_q;
  assign bus.saida     = seg_w;
  assign bus.dbg_state = state_q;
endmodule
